mutation_scheduler: RTL and testbench

Sequences the shared mutation engine across the 10 selected parents to build the 50-path mutant population, 5 children per parent. Child 0 of each parent is an unmutated elite copy; children 1-4 are each obtained by one req/ack transaction with the single engine instance. The block advances a 32-bit LFSR so every engine request carries a distinct seed. It sits between selection (sel_population) and the next-generation population register (mutant_pop).

---
 rtl/mutation_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mutation_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutation_scheduler.sv
// mutation_scheduler: steps the selected parents through the single shared mutation
// engine. Each parent gets one elite copy and four mutants, all written into mutant_pop.
module mutation_scheduler #(
    parameter int PATH_W    = 150,
    parameter int N_PARENTS = 10,
    parameter int N_CHILD   = 5,
    parameter int SEED_W    = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [N_PARENTS*PATH_W-1:0]         sel_population,
    input  logic [SEED_W-1:0]                   prg_seed,
    output logic                                eng_req,
    output logic [PATH_W-1:0]                   eng_parent,
    output logic [SEED_W-1:0]                   eng_seed,
    input  logic                                eng_ack,
    input  logic [PATH_W-1:0]                   eng_child,
    output logic [N_PARENTS*N_CHILD*PATH_W-1:0] mutant_pop,
    output logic                                busy,
    output logic                                done
);
    localparam int N_SLOTS = N_PARENTS * N_CHILD;
    localparam int POP_W   = N_SLOTS * PATH_W;
    localparam int SEL_W   = N_PARENTS * PATH_W;
    localparam int P_W     = $clog2(N_PARENTS);
    localparam int C_W     = $clog2(N_CHILD);
    localparam logic [P_W-1:0]    LAST_P = P_W'(N_PARENTS - 1);
    localparam logic [C_W-1:0]    LAST_C = C_W'(N_CHILD - 1);
    localparam logic [SEED_W-1:0] POLY   = SEED_W'(32'h80200003);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_REQ, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    snap_q, snap_d;
    logic [SEED_W-1:0]   lfsr_q, lfsr_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [C_W-1:0]      c_q, c_d;
    logic                eng_req_q, eng_req_d;
    logic [PATH_W-1:0]   eng_parent_q, eng_parent_d;
    logic [SEED_W-1:0]   eng_seed_q, eng_seed_d;
    logic [POP_W-1:0]    mutant_pop_q, mutant_pop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PATH_W-1:0]   parent_cur;
    logic [SEED_W-1:0]   lfsr_next;
    logic                handshake;
    int                  par_lsb;
    int                  slot_lsb;

    // Engine link: a transfer happens on an edge where eng_req and eng_ack are both
    // high; eng_req and its payload hold until then and drop for one GAP cycle after.
    always_comb begin
        par_lsb    = (N_PARENTS - 1 - int'(p_q)) * PATH_W;
        slot_lsb   = (N_SLOTS - 1 - (int'(p_q) * N_CHILD + int'(c_q))) * PATH_W;
        parent_cur = snap_q[par_lsb +: PATH_W];
        lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        handshake  = eng_req_q && eng_ack;
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        lfsr_d       = lfsr_q;
        p_d          = p_q;
        c_d          = c_q;
        eng_req_d    = eng_req_q;
        eng_parent_d = eng_parent_q;
        eng_seed_d   = eng_seed_q;
        mutant_pop_d = mutant_pop_q;
        busy_d       = busy_q;
        done_d       = done_q;

        if (abort && state_q != S_IDLE) begin
            // A handshake landing on the abort edge is dropped.
            state_d   = S_IDLE;
            eng_req_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        snap_d  = sel_population;
                        lfsr_d  = (prg_seed == '0) ? SEED_W'(1) : prg_seed;
                        p_d     = '0;
                        c_d     = '0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_COPY;
                    end
                end
                S_COPY: begin
                    mutant_pop_d[slot_lsb +: PATH_W] = parent_cur;
                    c_d          = C_W'(1);
                    eng_req_d    = 1'b1;
                    eng_parent_d = parent_cur;
                    eng_seed_d   = lfsr_q;
                    state_d      = S_REQ;
                end
                S_REQ: begin
                    if (handshake) begin
                        mutant_pop_d[slot_lsb +: PATH_W] = eng_child;
                        lfsr_d    = lfsr_next;
                        eng_req_d = 1'b0;
                        state_d   = S_GAP;
                    end
                end
                S_GAP: begin
                    if (c_q < LAST_C) begin
                        c_d          = c_q + C_W'(1);
                        eng_req_d    = 1'b1;
                        eng_parent_d = parent_cur;
                        eng_seed_d   = lfsr_q;
                        state_d      = S_REQ;
                    end else if (p_q < LAST_P) begin
                        p_d     = p_q + P_W'(1);
                        c_d     = '0;
                        state_d = S_COPY;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            lfsr_q       <= '0;
            p_q          <= '0;
            c_q          <= '0;
            eng_req_q    <= 1'b0;
            eng_parent_q <= '0;
            eng_seed_q   <= '0;
            mutant_pop_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            lfsr_q       <= lfsr_d;
            p_q          <= p_d;
            c_q          <= c_d;
            eng_req_q    <= eng_req_d;
            eng_parent_q <= eng_parent_d;
            eng_seed_q   <= eng_seed_d;
            mutant_pop_q <= mutant_pop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign eng_req    = eng_req_q;
    assign eng_parent = eng_parent_q;
    assign eng_seed   = eng_seed_q;
    assign mutant_pop = mutant_pop_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mutation_scheduler.sv
// Bench for mutation_scheduler: table of full runs scored against a seed/parent
// queue and an expected population, plus hand-written abort, idle and reset sequences.
module tb_mutation_scheduler;
    localparam int PATH_W    = 150;
    localparam int N_PARENTS = 10;
    localparam int N_CHILD   = 5;
    localparam int SEED_W    = 32;
    localparam int N_SLOTS   = N_PARENTS * N_CHILD;
    localparam int N_HS      = N_PARENTS * (N_CHILD - 1);

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start;
    logic                        abort;
    logic [N_PARENTS*PATH_W-1:0] sel_population;
    logic [SEED_W-1:0]           prg_seed;
    logic                        eng_req;
    logic [PATH_W-1:0]           eng_parent;
    logic [SEED_W-1:0]           eng_seed;
    logic                        eng_ack;
    logic [PATH_W-1:0]           eng_child;
    logic [N_SLOTS*PATH_W-1:0]   mutant_pop;
    logic                        busy;
    logic                        done;

    mutation_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sel_population(sel_population), .prg_seed(prg_seed),
        .eng_req(eng_req), .eng_parent(eng_parent), .eng_seed(eng_seed),
        .eng_ack(eng_ack), .eng_child(eng_child),
        .mutant_pop(mutant_pop), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] seed;
        int          max_wait;
        bit          noisy;
        int          exp_edges;
        logic [31:0] exp_seed0;
        logic [31:0] exp_seed1;
    } run_vec_t;

    run_vec_t          vecs[4];
    logic [31:0]       exp_q[$];
    logic [31:0]       obs_seed[2];
    logic [PATH_W-1:0] hold_parent;
    logic [31:0]       hold_seed;
    int                n_checks = 0;
    int                n_errors = 0;
    int                hs_count;
    int                par_base;
    int                wait_left;
    bit                in_req;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_w32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_path(input string name, input logic [PATH_W-1:0] act,
                              input logic [PATH_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [PATH_W-1:0] exp_slot(input int k, input int base);
        logic [PATH_W-1:0] v;
        v = PATH_W'(k / N_CHILD + base);
        return (k % N_CHILD == 0) ? v : ~v;
    endfunction

    function automatic logic [PATH_W-1:0] get_slot(input int k);
        return mutant_pop[(N_SLOTS - 1 - k) * PATH_W +: PATH_W];
    endfunction

    task automatic set_parents(input int base);
        for (int p = 0; p < N_PARENTS; p++)
            sel_population[(N_PARENTS - 1 - p) * PATH_W +: PATH_W] = PATH_W'(p + base);
    endtask

    task automatic load_exp(input logic [31:0] seed);
        logic [31:0] l;
        l = (seed == 32'h0) ? 32'h1 : seed;
        exp_q.delete();
        for (int i = 0; i < N_HS; i++) begin
            exp_q.push_back(l);
            l = lfsr_step(l);
        end
        hs_count = 0;
        in_req   = 1'b0;
    endtask

    // Engine model, called once per negedge: random wait, then ack with ~parent.
    task automatic engine_step(input int max_wait, input bit noisy);
        logic [31:0] es;
        if (eng_req) begin
            if (!in_req) begin
                in_req      = 1'b1;
                wait_left   = $urandom_range(0, max_wait);
                hold_parent = eng_parent;
                hold_seed   = eng_seed;
            end else begin
                check_path("hold_parent", eng_parent, hold_parent);
                check_w32("hold_seed", eng_seed, hold_seed);
            end
            if (wait_left == 0) begin
                eng_ack   = 1'b1;
                eng_child = ~eng_parent;
                if (hs_count < 2) obs_seed[hs_count] = eng_seed;
                if (exp_q.size() == 0) begin
                    check_w32("extra_handshake", 32'(hs_count), 32'(N_HS - 1));
                end else begin
                    es = exp_q.pop_front();
                    check_w32($sformatf("seed[%0d]", hs_count), eng_seed, es);
                end
                check_path($sformatf("parent[%0d]", hs_count), eng_parent,
                           PATH_W'(hs_count / (N_CHILD - 1) + par_base));
                hs_count++;
                in_req = 1'b0;
            end else begin
                eng_ack = 1'b0;
                wait_left--;
            end
        end else begin
            in_req    = 1'b0;
            eng_ack   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            eng_child = PATH_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end
    endtask

    task automatic run_vec(input run_vec_t v, input int idx);
        int edges;
        bit finished;
        set_parents(1);
        par_base = 1;
        load_exp(v.seed);
        @(negedge clk);
        start    = 1'b1;
        prg_seed = v.seed;
        @(posedge clk);
        edges    = 1;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check_bit($sformatf("v%0d busy_after_start", idx), busy, 1'b1);
                check_bit($sformatf("v%0d done_after_start", idx), done, 1'b0);
            end
            if (done) begin
                finished = 1'b1;
            end else begin
                start = v.noisy ? ($urandom_range(0, 7) == 0) : 1'b0;
                if (v.noisy && cyc == 40) begin
                    sel_population = {10{$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}};
                    prg_seed       = $urandom();
                end
                engine_step(v.max_wait, v.noisy);
                @(posedge clk);
                edges++;
            end
        end
        start   = 1'b0;
        eng_ack = 1'b0;
        check_bit($sformatf("v%0d run_finished", idx), finished, 1'b1);
        if (v.exp_edges > 0)
            check_w32($sformatf("v%0d done_edge", idx), 32'(edges), 32'(v.exp_edges));
        check_bit($sformatf("v%0d busy_end", idx), busy, 1'b0);
        check_bit($sformatf("v%0d eng_req_end", idx), eng_req, 1'b0);
        check_w32($sformatf("v%0d handshakes", idx), 32'(hs_count), 32'(N_HS));
        check_w32($sformatf("v%0d first_seed", idx), obs_seed[0], v.exp_seed0);
        check_w32($sformatf("v%0d second_seed", idx), obs_seed[1], v.exp_seed1);
        for (int k = 0; k < N_SLOTS; k++)
            check_path($sformatf("v%0d slot[%0d]", idx, k), get_slot(k), exp_slot(k, 1));
    endtask

    initial begin
        bit aborted;
        bit reached;

        vecs[0] = '{seed: 32'h1, max_wait: 0, noisy: 1'b0, exp_edges: 91,
                    exp_seed0: 32'h1, exp_seed1: 32'h80200003};
        vecs[1] = '{seed: 32'h0, max_wait: 0, noisy: 1'b0, exp_edges: 91,
                    exp_seed0: 32'h1, exp_seed1: 32'h80200003};
        vecs[2] = '{seed: 32'h1, max_wait: 7, noisy: 1'b0, exp_edges: -1,
                    exp_seed0: 32'h1, exp_seed1: 32'h80200003};
        vecs[3] = '{seed: 32'hDEADBEEF, max_wait: 3, noisy: 1'b1, exp_edges: -1,
                    exp_seed0: 32'hDEADBEEF, exp_seed1: 32'hEF76DF74};

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        eng_ack        = 1'b0;
        eng_child      = '0;
        prg_seed       = '0;
        sel_population = '0;
        #3;
        check_bit("reset eng_req", eng_req, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check_bit("reset pop_zero", |mutant_pop, 1'b0);
        check_w32("reset eng_seed", eng_seed, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // abort while idle leaves the completed run's done flag alone
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_bit("idle_abort done", done, 1'b1);
        check_bit("idle_abort busy", busy, 1'b0);

        // abort on parent 3 child 2 request, with a same-cycle ack
        set_parents(100);
        par_base = 100;
        load_exp(32'h1);
        @(negedge clk);
        start    = 1'b1;
        prg_seed = 32'h1;
        aborted  = 1'b0;
        for (int cyc = 0; cyc < 500 && !aborted; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (eng_req && hs_count == 13) begin
                abort     = 1'b1;
                eng_ack   = 1'b1;
                eng_child = ~eng_parent;
                aborted   = 1'b1;
            end else begin
                engine_step(0, 1'b0);
            end
        end
        check_bit("abort reached", aborted, 1'b1);
        @(negedge clk);
        abort   = 1'b0;
        check_bit("abort busy", busy, 1'b0);
        check_bit("abort done", done, 1'b0);
        check_bit("abort eng_req", eng_req, 1'b0);
        eng_ack = 1'b1;
        repeat (3) @(negedge clk);
        eng_ack = 1'b0;
        check_bit("abort stays_idle", busy, 1'b0);
        for (int k = 0; k < N_SLOTS; k++)
            check_path($sformatf("abort slot[%0d]", k), get_slot(k),
                       (k <= 16) ? exp_slot(k, 100) : exp_slot(k, 1));

        // start and abort together in idle: no run
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_bit("start_abort busy", busy, 1'b0);
        @(negedge clk);
        check_bit("start_abort eng_req", eng_req, 1'b0);
        check_path("start_abort slot[17]", get_slot(17), exp_slot(17, 1));

        // asynchronous reset while a request is pending
        set_parents(1);
        @(negedge clk);
        start    = 1'b1;
        prg_seed = 32'h1;
        eng_ack  = 1'b0;
        reached  = 1'b0;
        for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (eng_req) reached = 1'b1;
        end
        check_bit("rst_mid reached_req", reached, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("rst_mid eng_req", eng_req, 1'b0);
        check_bit("rst_mid busy", busy, 1'b0);
        check_bit("rst_mid done", done, 1'b0);
        check_bit("rst_mid pop_zero", |mutant_pop, 1'b0);
        check_path("rst_mid eng_parent", eng_parent, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("rst_release busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
